// File: rtl/core_mmio_router.sv
// Routes core data-memory requests to the memory bus or the MMIO port and returns responses in request order.
// Optional CORE_MMIO_STRB_CHECK_EN: partial-strobe MMIO writes are answered locally with an error.
module core_mmio_router #(
    parameter logic [63:0] MMIO_BASE       = 64'h0000_0000_0001_0000,
    parameter logic [63:0] MMIO_RANGE_MASK = 64'h0000_0000_0000_FFFF,
    parameter int unsigned OUTSTANDING     = 2
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        cpu_req,
    output logic        cpu_gnt,
    input  logic        cpu_wen,
    input  logic [7:0]  cpu_strb,
    input  logic [63:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    output logic        cpu_recv,
    input  logic        cpu_ack,
    output logic [63:0] cpu_rdata,
    output logic        cpu_error,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [7:0]  mem_strb,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_recv,
    output logic        mem_ack,
    input  logic [63:0] mem_rdata,
    input  logic        mem_error,
    output logic        mmio_req,
    output logic        mmio_wen,
    output logic [63:0] mmio_addr,
    output logic [63:0] mmio_wdata,
    input  logic        mmio_gnt,
    input  logic [63:0] mmio_rdata,
    input  logic        mmio_error
);
    localparam int unsigned PW = $clog2(OUTSTANDING);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(OUTSTANDING);

    typedef enum logic {
        TAG_MEM = 1'b0,
        TAG_IO  = 1'b1
    } tag_e;

    tag_e          tags [OUTSTANDING];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    tag_e          head;
    logic          q_empty;
    logic          q_full;
    logic          io_in_q;

    logic          buf_full;
    logic          buf_wen;
    logic          buf_error;
    logic [63:0]   buf_rdata;
    logic          io_pend;
    logic          io_pend_wen;
    logic          io_pend_bad;

    logic          hit;
    logic          strb_bad;
    logic          mem_ok;
    logic          io_ok;
    logic          push;
    logic          pop;

    assign hit = (cpu_addr & ~MMIO_RANGE_MASK) == MMIO_BASE;

`ifdef CORE_MMIO_STRB_CHECK_EN
    assign strb_bad = cpu_wen && (cpu_strb != 8'hFF);
`else
    assign strb_bad = 1'b0;
`endif

    assign q_empty = (count == '0);
    assign q_full  = (count == DEPTH);
    assign head    = tags[rd_ptr];
    // An IO entry is only ever pushed into an empty queue, so it can only sit at the head.
    assign io_in_q = !q_empty && (head == TAG_IO);

    // Accept conditions depend on registered state only, keeping cpu_ack off the cpu_gnt path.
    assign mem_ok = !q_full && !buf_full && !io_in_q;
    assign io_ok  = q_empty && !buf_full;

    assign mem_req   = cpu_req && !hit && mem_ok;
    assign mem_wen   = cpu_wen;
    assign mem_strb  = cpu_strb;
    assign mem_addr  = cpu_addr;
    assign mem_wdata = cpu_wdata;

    assign mmio_req   = cpu_req && hit && io_ok && !strb_bad;
    assign mmio_wen   = cpu_wen;
    assign mmio_addr  = cpu_addr;
    assign mmio_wdata = cpu_wdata;

    assign cpu_gnt = hit ? (io_ok && (strb_bad || mmio_gnt)) : (mem_ok && mem_gnt);
    assign push    = cpu_req && cpu_gnt;

    always_comb begin
        cpu_recv  = 1'b0;
        cpu_rdata = '0;
        cpu_error = 1'b0;
        mem_ack   = 1'b0;
        if (!q_empty) begin
            if (head == TAG_MEM) begin
                cpu_recv  = mem_recv;
                cpu_rdata = mem_rdata;
                cpu_error = mem_error;
                mem_ack   = cpu_ack;
            end else begin
                cpu_recv  = buf_full;
                cpu_rdata = buf_wen ? '0 : buf_rdata;
                cpu_error = buf_error;
            end
        end
    end

    assign pop = cpu_recv && cpu_ack;

    always_ff @(posedge g_clk) begin
        if (push) begin
            tags[wr_ptr] <= hit ? TAG_IO : TAG_MEM;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            buf_full    <= 1'b0;
            buf_wen     <= 1'b0;
            buf_error   <= 1'b0;
            buf_rdata   <= '0;
            io_pend     <= 1'b0;
            io_pend_wen <= 1'b0;
            io_pend_bad <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            io_pend     <= push && hit;
            io_pend_wen <= cpu_wen;
            io_pend_bad <= strb_bad;

            // MMIO response is fixed-latency: capture it the cycle after acceptance.
            if (io_pend) begin
                buf_full  <= 1'b1;
                buf_wen   <= io_pend_wen;
                buf_error <= io_pend_bad || mmio_error;
                buf_rdata <= io_pend_bad ? '0 : mmio_rdata;
            end else if (pop && (head == TAG_IO)) begin
                buf_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_core_mmio_router.sv
// Directed self-checking bench for core_mmio_router (default parameters).
module tb_core_mmio_router;
    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        cpu_req;
    logic        cpu_gnt;
    logic        cpu_wen;
    logic [7:0]  cpu_strb;
    logic [63:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic        cpu_recv;
    logic        cpu_ack;
    logic [63:0] cpu_rdata;
    logic        cpu_error;
    logic        mem_req;
    logic        mem_wen;
    logic [7:0]  mem_strb;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_recv;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        mem_error;
    logic        mmio_req;
    logic        mmio_wen;
    logic [63:0] mmio_addr;
    logic [63:0] mmio_wdata;
    logic        mmio_gnt;
    logic [63:0] mmio_rdata;
    logic        mmio_error;

    int checks   = 0;
    int failures = 0;
    logic watch_mmio = 1'b0;
    logic mmio_seen  = 1'b0;

    core_mmio_router #(
        .MMIO_BASE      (64'h0000_0000_0001_0000),
        .MMIO_RANGE_MASK(64'h0000_0000_0000_FFFF),
        .OUTSTANDING    (2)
    ) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .cpu_req   (cpu_req),
        .cpu_gnt   (cpu_gnt),
        .cpu_wen   (cpu_wen),
        .cpu_strb  (cpu_strb),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_recv  (cpu_recv),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_error (cpu_error),
        .mem_req   (mem_req),
        .mem_wen   (mem_wen),
        .mem_strb  (mem_strb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_recv  (mem_recv),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_error (mem_error),
        .mmio_req  (mmio_req),
        .mmio_wen  (mmio_wen),
        .mmio_addr (mmio_addr),
        .mmio_wdata(mmio_wdata),
        .mmio_gnt  (mmio_gnt),
        .mmio_rdata(mmio_rdata),
        .mmio_error(mmio_error)
    );

    always #5 g_clk = ~g_clk;

    always @(negedge g_clk) begin
        if (watch_mmio && mmio_req) mmio_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic wen, input logic [7:0] strb,
                         input logic [63:0] addr, input logic [63:0] wdata);
        cpu_req   = req;
        cpu_wen   = wen;
        cpu_strb  = strb;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    initial begin
        g_resetn   = 1'b0;
        drive(1'b0, 1'b0, 8'hFF, 64'h0, 64'h0);
        cpu_ack    = 1'b0;
        mem_gnt    = 1'b0;
        mem_recv   = 1'b0;
        mem_rdata  = 64'h0;
        mem_error  = 1'b0;
        mmio_gnt   = 1'b0;
        mmio_rdata = 64'h0;
        mmio_error = 1'b0;
        step();
        step();

        // Reset state
        check("rst_cpu_recv", 64'(cpu_recv), 64'h0);
        check("rst_cpu_rdata", cpu_rdata, 64'h0);
        check("rst_cpu_error", 64'(cpu_error), 64'h0);
        check("rst_mem_req", 64'(mem_req), 64'h0);
        check("rst_mmio_req", 64'(mmio_req), 64'h0);
        g_resetn = 1'b1;
        step();

        // 1: memory read, response 3 cycles later
        watch_mmio = 1'b1;
        drive(1'b1, 1'b0, 8'hFF, 64'h8000_0000, 64'h0);
        mem_gnt = 1'b1;
        #1;
        check("t1_mem_req", 64'(mem_req), 64'h1);
        check("t1_cpu_gnt", 64'(cpu_gnt), 64'h1);
        check("t1_mem_addr", mem_addr, 64'h8000_0000);
        step();
        cpu_req = 1'b0;
        #1;
        check("t1_no_recv_yet", 64'(cpu_recv), 64'h0);
        step();
        step();
        mem_recv  = 1'b1;
        mem_rdata = 64'hDEAD;
        cpu_ack   = 1'b1;
        #1;
        check("t1_cpu_recv", 64'(cpu_recv), 64'h1);
        check("t1_cpu_rdata", cpu_rdata, 64'hDEAD);
        check("t1_mem_ack", 64'(mem_ack), 64'h1);
        step();
        mem_recv = 1'b0;
        cpu_ack  = 1'b0;
        #1;
        watch_mmio = 1'b0;
        check("t1_mmio_never", 64'(mmio_seen), 64'h0);

        // 2: MMIO read with a 4-cycle response stall
        drive(1'b1, 1'b0, 8'hFF, 64'h1_0000, 64'h0);
        mmio_gnt = 1'b1;
        #1;
        check("t2_mmio_req", 64'(mmio_req), 64'h1);
        check("t2_cpu_gnt", 64'(cpu_gnt), 64'h1);
        check("t2_mem_req", 64'(mem_req), 64'h0);
        step();
        cpu_req    = 1'b0;
        mmio_rdata = 64'h1234;
        #1;
        check("t2_recv_before_capture", 64'(cpu_recv), 64'h0);
        step();
        mmio_rdata = 64'hBAD0;
        drive(1'b1, 1'b0, 8'hFF, 64'h8000_0000, 64'h0);
        #1;
        check("t2_mem_blocked_gnt", 64'(cpu_gnt), 64'h0);
        check("t2_mem_blocked_req", 64'(mem_req), 64'h0);
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_stall_recv", 64'(cpu_recv), 64'h1);
            check("t2_stall_rdata", cpu_rdata, 64'h1234);
            step();
        end
        cpu_ack = 1'b1;
        #1;
        check("t2_ack_recv", 64'(cpu_recv), 64'h1);
        check("t2_ack_error", 64'(cpu_error), 64'h0);
        step();
        cpu_ack = 1'b0;
        #1;
        check("t2_after_recv", 64'(cpu_recv), 64'h0);
        drive(1'b1, 1'b0, 8'hFF, 64'h1_0000, 64'h0);
        #1;
        check("t2_queue_empty", 64'(mmio_req), 64'h1);
        cpu_req  = 1'b0;
        mmio_gnt = 1'b0;

        // 3: queue full with OUTSTANDING=2, ordering
        drive(1'b1, 1'b0, 8'hFF, 64'h8000_0010, 64'h0);
        mem_gnt = 1'b1;
        #1;
        check("t3_gnt1", 64'(cpu_gnt), 64'h1);
        step();
        cpu_addr = 64'h8000_0020;
        #1;
        check("t3_gnt2", 64'(cpu_gnt), 64'h1);
        step();
        cpu_addr = 64'h8000_0030;
        #1;
        check("t3_gnt3_full", 64'(cpu_gnt), 64'h0);
        check("t3_req3_full", 64'(mem_req), 64'h0);
        step();
        mem_recv  = 1'b1;
        mem_rdata = 64'h1111;
        cpu_ack   = 1'b1;
        #1;
        check("t3_full_pop_no_gnt", 64'(cpu_gnt), 64'h0);
        check("t3_rdata1", cpu_rdata, 64'h1111);
        step();
        mem_rdata = 64'h2222;
        #1;
        check("t3_gnt3_after_pop", 64'(cpu_gnt), 64'h1);
        check("t3_rdata2", cpu_rdata, 64'h2222);
        step();
        cpu_req   = 1'b0;
        mem_rdata = 64'h3333;
        #1;
        check("t3_recv3", 64'(cpu_recv), 64'h1);
        check("t3_rdata3", cpu_rdata, 64'h3333);
        step();
        mem_recv = 1'b0;
        cpu_ack  = 1'b0;
        #1;
        check("t3_drained", 64'(cpu_recv), 64'h0);

        // 4: MMIO write held off behind an outstanding memory request
        drive(1'b1, 1'b0, 8'hFF, 64'h8000_0040, 64'h0);
        #1;
        check("t4_mem_gnt", 64'(cpu_gnt), 64'h1);
        step();
        drive(1'b1, 1'b1, 8'hFF, 64'h1_0008, 64'hCAFE);
        mmio_gnt = 1'b1;
        #1;
        check("t4_mmio_held_req", 64'(mmio_req), 64'h0);
        check("t4_mmio_held_gnt", 64'(cpu_gnt), 64'h0);
        step();
        mem_recv  = 1'b1;
        mem_rdata = 64'h4444;
        cpu_ack   = 1'b1;
        #1;
        check("t4_mem_resp_first", cpu_rdata, 64'h4444);
        check("t4_mmio_still_held", 64'(mmio_req), 64'h0);
        step();
        mem_recv = 1'b0;
        cpu_ack  = 1'b0;
        #1;
        check("t4_mmio_req", 64'(mmio_req), 64'h1);
        check("t4_mmio_gnt", 64'(cpu_gnt), 64'h1);
        check("t4_mmio_wen", 64'(mmio_wen), 64'h1);
        check("t4_mmio_addr", mmio_addr, 64'h1_0008);
        check("t4_mmio_wdata", mmio_wdata, 64'hCAFE);
        step();
        cpu_req    = 1'b0;
        mmio_rdata = 64'h55;
        mmio_error = 1'b0;
        step();
        mem_recv  = 1'b1;
        mem_rdata = 64'h9999;
        #1;
        check("t4_io_recv", 64'(cpu_recv), 64'h1);
        check("t4_write_rdata_zero", cpu_rdata, 64'h0);
        check("t4_stray_mem_ack", 64'(mem_ack), 64'h0);
        cpu_ack = 1'b1;
        step();
        cpu_ack  = 1'b0;
        mem_recv = 1'b0;
        #1;
        check("t4_io_popped", 64'(cpu_recv), 64'h0);

        // 5: MMIO write with partial strobes
        drive(1'b1, 1'b1, 8'h0F, 64'h1_0008, 64'hABCD);
`ifdef CORE_MMIO_STRB_CHECK_EN
        mmio_gnt = 1'b0;
        #1;
        check("t5_strb_mmio_req", 64'(mmio_req), 64'h0);
        check("t5_strb_gnt", 64'(cpu_gnt), 64'h1);
        step();
        cpu_req    = 1'b0;
        mmio_rdata = 64'h77;
        mmio_error = 1'b0;
        step();
        check("t5_strb_recv", 64'(cpu_recv), 64'h1);
        check("t5_strb_error", 64'(cpu_error), 64'h1);
        check("t5_strb_rdata", cpu_rdata, 64'h0);
`else
        mmio_gnt = 1'b1;
        #1;
        check("t5_strb_mmio_req", 64'(mmio_req), 64'h1);
        check("t5_strb_gnt", 64'(cpu_gnt), 64'h1);
        step();
        cpu_req    = 1'b0;
        mmio_rdata = 64'h77;
        mmio_error = 1'b0;
        step();
        check("t5_strb_recv", 64'(cpu_recv), 64'h1);
        check("t5_strb_error", 64'(cpu_error), 64'h0);
`endif
        cpu_ack = 1'b1;
        step();
        cpu_ack  = 1'b0;
        mmio_gnt = 1'b0;

        // 6: reset with two memory requests outstanding
        drive(1'b1, 1'b0, 8'hFF, 64'h8000_0050, 64'h0);
        mem_gnt = 1'b1;
        step();
        cpu_addr = 64'h8000_0058;
        step();
        cpu_req   = 1'b0;
        mem_recv  = 1'b1;
        mem_rdata = 64'h6666;
        #1;
        check("t6_recv_before_rst", 64'(cpu_recv), 64'h1);
        g_resetn = 1'b0;
        step();
        check("t6_recv_after_rst", 64'(cpu_recv), 64'h0);
        g_resetn = 1'b1;
        cpu_ack  = 1'b1;
        #1;
        check("t6_late_mem_ack", 64'(mem_ack), 64'h0);
        check("t6_late_recv", 64'(cpu_recv), 64'h0);
        step();
        mem_recv = 1'b0;
        cpu_ack  = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/core_mmio_router.md
Name: core_mmio_router

Overview:
- Sits between the core data-memory port and two targets: the external memory bus and the counter/timer MMIO port.
- Decodes each accepted request by address and forwards it to exactly one target.
- Tracks outstanding responses, buffers the fixed-latency MMIO response, and returns all responses to the core in request order.

Parameters:
- MMIO_BASE, 'h0000_0000_0001_0000, base address of the MMIO region.
- MMIO_RANGE_MASK, 'h0000_0000_0000_FFFF, offset bits inside the region. A hit is (addr & ~MMIO_RANGE_MASK) == MMIO_BASE.
- OUTSTANDING, 2, maximum in-flight memory-bus requests (power of two, 2..8).

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  synchronous reset, active-low
- cpu_req  in  1  core request valid
- cpu_gnt  out  1  request accepted this cycle (cpu_req && cpu_gnt)
- cpu_wen  in  1  write enable
- cpu_strb  in  8  byte strobes
- cpu_addr  in  64  address
- cpu_wdata  in  64  write data
- cpu_recv  out  1  response valid
- cpu_ack  in  1  core accepts response
- cpu_rdata  out  64  response read data
- cpu_error  out  1  response error
- mem_req, mem_wen, mem_strb, mem_addr, mem_wdata  out  1/1/8/64/64  memory-bus request; mirrors cpu_*
- mem_gnt  in  1  memory-bus grant
- mem_recv  in  1  memory-bus response valid
- mem_ack  out  1  response accept; equals cpu_ack while a memory response is at the queue head
- mem_rdata  in  64  memory-bus read data
- mem_error  in  1  memory-bus error
- mmio_req, mmio_wen  out  1  MMIO request and write enable
- mmio_addr  out  64  MMIO address
- mmio_wdata  out  64  MMIO write data
- mmio_gnt  in  1  MMIO grant
- mmio_rdata  in  64  MMIO read data; valid the cycle after acceptance
- mmio_error  in  1  MMIO error; valid the cycle after acceptance

Behaviour:
- Reset values: cpu_recv=0, cpu_rdata=0, cpu_error=0, mem_req=0, mmio_req=0. Order queue empty, MMIO buffer empty.
- Decode: hit = MMIO region. Request outputs are combinational from cpu_* and gated by the target enable. cpu_gnt is the target's gnt ANDed with the router accept condition.
- Memory accept condition:
  - queue not full (fewer than OUTSTANDING entries), and
  - MMIO buffer empty, and
  - no MMIO entry in the queue.
  - Accepted memory requests push tag MEM into the order queue.
- MMIO accept condition: queue empty and buffer empty. This keeps MMIO strictly ordered against memory traffic.
  - Acceptance pushes tag IO.
  - On the next cycle the router captures mmio_rdata and mmio_error into the buffer unconditionally, marks the buffer full and stores the write flag.
- Response path when the head tag is MEM: cpu_recv=mem_recv, cpu_rdata=mem_rdata, cpu_error=mem_error, mem_ack=cpu_ack. The head pops on mem_recv && cpu_ack.
- Response path when the head tag is IO: cpu_recv=buffer full.
  - Reads return the buffered rdata; writes return rdata=0. cpu_error comes from the buffer.
  - Head pops and buffer clears on cpu_recv && cpu_ack.
- Empty queue: cpu_recv=0, mem_ack=0.
  - A mem_recv with an empty queue or an IO head is ignored, not acked, and sets no state.
- Simultaneous push and pop: allowed, and the queue count is unchanged. A full queue with a pop in the same cycle still refuses the push; no combinational path from cpu_ack to cpu_gnt.
- Queue: circular buffer of 1-bit tags. Pointers are log2(OUTSTANDING) bits, wrapping modulo OUTSTANDING. Count is log2(OUTSTANDING)+1 bits.
- Reset mid-operation: all state clears in one cycle. In-flight bus responses after reset are ignored per the empty-queue rule.

Optional Feature:
- Macro: CORE_MMIO_STRB_CHECK_EN.
- When defined: an MMIO write with cpu_strb != 8'hFF is not forwarded (mmio_req stays 0).
  - The router accepts it itself under the MMIO accept condition.
  - It loads the buffer with error=1 and rdata=0 on the next cycle, in the same order slot.
- When undefined: all MMIO writes are forwarded as full 64-bit writes and strobes are ignored.

Test Plan:
- Memory read at 'h8000_0000, mem_gnt=1, mem_recv 3 cycles later with rdata 'hDEAD, cpu_ack=1 -> cpu_recv=1 with cpu_rdata='hDEAD, mmio_req never asserted.
- MMIO read at 'h1_0000, mmio_rdata='h1234 the cycle after grant, cpu_ack held 0 for 4 cycles then 1 -> cpu_recv stays 1 with rdata 'h1234 across the stall; queue empty afterwards.
- Two memory requests back-to-back then a third with OUTSTANDING=2 -> third cpu_gnt=0 until the first response pops; the second response is returned before the third.
- Memory request outstanding, then MMIO request at 'h1_0008 -> mmio_req=0 and cpu_gnt=0 until the memory response pops; then forwarded, and the response order is preserved.
- With CORE_MMIO_STRB_CHECK_EN, MMIO write at 'h1_0008 with strb 'h0F -> mmio_req=0, and the next cycle gives cpu_recv=1, cpu_error=1.
- g_resetn deasserted while two memory requests are outstanding -> cpu_recv=0 next cycle; a late mem_recv=1 is not acked (mem_ack=0).
